vx_decode_ibuf: RTL and testbench

- Per-warp instruction buffer between decode and issue, generalised to NUM_LANES issue lanes and configurable per-warp depth.
- Accepts one decoded packet per cycle and queues it in the FIFO of its warp.
- Each lane arbitrates round-robin over its warps (wid % NUM_LANES == lane) and presents one packet per cycle.
- Produces the per-warp ibuf_pop credit pulses the fetch scheduler consumes.

---
 rtl/vx_decode_ibuf_pkg.sv | 22 ++
 rtl/vx_ibuf_fifo.sv | 74 +++++++
 rtl/vx_decode_ibuf.sv | 161 ++++++++++++++++
 tb/tb_vx_decode_ibuf.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_decode_ibuf_pkg.sv
// Shared types and helpers for the per-warp decode instruction buffer.
package vx_decode_ibuf_pkg;

  localparam int IBUF_NUM_WARPS = 4;
  localparam int IBUF_NUM_LANES = 1;
  localparam int IBUF_DEPTH     = 2;
  localparam int IBUF_DATAW     = 64;
  localparam int IBUF_NW_WIDTH  = (IBUF_NUM_WARPS > 1) ? $clog2(IBUF_NUM_WARPS) : 1;
  localparam int IBUF_CNT_W     = $clog2(IBUF_DEPTH + 1);

  // One buffered decode packet as seen on an issue lane.
  typedef struct packed {
    logic [IBUF_NW_WIDTH-1:0] wid;
    logic [IBUF_DATAW-1:0]    payload;
  } ibuf_entry_t;

  // Issue lane that owns a warp.
  function automatic int unsigned lane_of(input int unsigned wid, input int unsigned num_lanes);
    return wid % num_lanes;
  endfunction

endpackage

// File: rtl/vx_ibuf_fifo.sv
// Single-warp circular FIFO with occupancy count and asynchronous-read head.
module vx_ibuf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every output of a combinational block is defaulted first so no path can infer a latch.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count makes stale entries unobservable and keeps it RAM-friendly.
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vx_decode_ibuf.sv
// Per-warp decode instruction buffer feeding NUM_LANES issue lanes with
// round-robin warp arbitration per lane and per-warp ibuf_pop credits.
// Optional zero-latency bypass into an idle lane: define DECODE_IBUF_BYPASS_EN.
module vx_decode_ibuf
  import vx_decode_ibuf_pkg::*;
#(
  parameter int NUM_WARPS = IBUF_NUM_WARPS,
  parameter int NUM_LANES = IBUF_NUM_LANES,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int DATAW     = IBUF_DATAW,
  parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dec_valid,
  input  logic [NW_WIDTH-1:0]           dec_wid,
  input  logic [DATAW-1:0]              dec_data,
  output logic                          dec_ready,
  output logic [NUM_LANES-1:0]          out_valid,
  output logic [NUM_LANES*NW_WIDTH-1:0] out_wid,
  output logic [NUM_LANES*DATAW-1:0]    out_data,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [NUM_WARPS-1:0]          ibuf_pop
);

  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int LANE_WARPS = NUM_WARPS / NUM_LANES;
  localparam int LW         = (LANE_WARPS > 1) ? $clog2(LANE_WARPS) : 1;

  logic [DATAW-1:0]    fifo_rdata [NUM_WARPS];
  logic [CNT_W-1:0]    fifo_count [NUM_WARPS];
  logic                fifo_empty [NUM_WARPS];
  logic                fifo_push  [NUM_WARPS];
  logic                fifo_pop   [NUM_WARPS];
  logic                lane_fire   [NUM_LANES];
  logic                lane_bypass [NUM_LANES];
  logic [NW_WIDTH-1:0] lane_gwid   [NUM_LANES];
  logic                dec_fire;

  // A full warp refuses input even if it pops this cycle.
  assign dec_ready = !reset && (fifo_count[dec_wid] != CNT_W'(DEPTH));
  assign dec_fire  = dec_valid && dec_ready;

  // Route pushes and pops to warp FIFOs; a bypassed packet never touches storage.
  always_comb begin
    int unsigned lane;
    lane = 0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      lane         = lane_of(w, NUM_LANES);
      fifo_push[w] = dec_fire && (int'(dec_wid) == w) && !lane_bypass[lane];
      fifo_pop[w]  = lane_fire[lane] && !lane_bypass[lane] && (int'(lane_gwid[lane]) == w);
      ibuf_pop[w]  = lane_fire[lane] && (int'(lane_gwid[lane]) == w);
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    vx_ibuf_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATAW),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push[w]),
      .pop   (fifo_pop[w]),
      .wdata (dec_data),
      .rdata (fifo_rdata[w]),
      .count (fifo_count[w]),
      .empty (fifo_empty[w])
    );
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]       lock_idx_q, lock_idx_d;
    logic                lock_vld_q, lock_vld_d;
    logic [LW-1:0]       grant_idx;
    logic                grant_vld;
    logic                byp_vld;
    logic [LW-1:0]       sel_idx;
    logic                sel_vld;
    logic [DATAW-1:0]    sel_data;
    logic [NW_WIDTH-1:0] sel_wid;
    logic                fire;

    // First nonempty lane-local warp at or after rr_ptr; a held grant wins.
    always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < LANE_WARPS; k++) begin
        idx = (int'(rr_ptr_q) + k) % LANE_WARPS;
        if (!grant_vld && !fifo_empty[idx * NUM_LANES + l]) begin
          grant_vld = 1'b1;
          grant_idx = LW'(idx);
        end
      end
      if (lock_vld_q) begin
        grant_vld = 1'b1;
        grant_idx = lock_idx_q;
      end
    end

`ifdef DECODE_IBUF_BYPASS_EN
    assign byp_vld = dec_fire && !grant_vld && (lane_of(int'(dec_wid), NUM_LANES) == l);
`else
    assign byp_vld = 1'b0;
`endif

    // Present either the FIFO head of the granted warp or the bypassed packet.
    always_comb begin
      sel_idx  = grant_idx;
      sel_vld  = grant_vld && !reset;
      sel_data = fifo_rdata[int'(grant_idx) * NUM_LANES + l];
      if (byp_vld) begin
        sel_idx  = LW'(int'(dec_wid) / NUM_LANES);
        sel_vld  = 1'b1;
        sel_data = dec_data;
      end
    end

    assign sel_wid        = NW_WIDTH'(int'(sel_idx) * NUM_LANES + l);
    assign fire           = sel_vld && out_ready[l];
    assign lane_fire[l]   = fire;
    assign lane_gwid[l]   = sel_wid;
    assign lane_bypass[l] = byp_vld && out_ready[l];

    assign out_valid[l]                      = sel_vld;
    assign out_wid[l*NW_WIDTH +: NW_WIDTH]   = sel_wid;
    assign out_data[l*DATAW +: DATAW]        = sel_data;

    // Advance round-robin on fire; lock the grant while the consumer stalls.
    always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
      if (fire) begin
        rr_ptr_d   = (int'(sel_idx) == LANE_WARPS - 1) ? '0 : sel_idx + 1'b1;
        lock_vld_d = 1'b0;
      end else if (sel_vld) begin
        lock_vld_d = 1'b1;
        lock_idx_d = sel_idx;
      end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        rr_ptr_q   <= '0;
        lock_vld_q <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        rr_ptr_q   <= rr_ptr_d;
        lock_vld_q <= lock_vld_d;
        lock_idx_q <= lock_idx_d;
      end
    end
  end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// Self-checking bench for vx_decode_ibuf: a single-lane instance checked
// through a scoreboard of expected issue order, plus a two-lane instance.
`timescale 1ns/1ps
module tb_vx_decode_ibuf;

`ifdef DECODE_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Single-lane instance (4 warps, depth 2).
  logic         a_dec_valid;
  logic [1:0]   a_dec_wid;
  logic [63:0]  a_dec_data;
  logic         a_dec_ready;
  logic [0:0]   a_out_valid;
  logic [1:0]   a_out_wid;
  logic [63:0]  a_out_data;
  logic [0:0]   a_out_ready;
  logic [3:0]   a_ibuf_pop;

  // Two-lane instance.
  logic         b_dec_valid;
  logic [1:0]   b_dec_wid;
  logic [63:0]  b_dec_data;
  logic         b_dec_ready;
  logic [1:0]   b_out_valid;
  logic [3:0]   b_out_wid;
  logic [127:0] b_out_data;
  logic [1:0]   b_out_ready;
  logic [3:0]   b_ibuf_pop;

  vx_decode_ibuf #(.NUM_WARPS(4), .NUM_LANES(1), .DEPTH(2), .DATAW(64)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (a_dec_valid),
    .dec_wid   (a_dec_wid),
    .dec_data  (a_dec_data),
    .dec_ready (a_dec_ready),
    .out_valid (a_out_valid),
    .out_wid   (a_out_wid),
    .out_data  (a_out_data),
    .out_ready (a_out_ready),
    .ibuf_pop  (a_ibuf_pop)
  );

  vx_decode_ibuf #(.NUM_WARPS(4), .NUM_LANES(2), .DEPTH(2), .DATAW(64)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (b_dec_valid),
    .dec_wid   (b_dec_wid),
    .dec_data  (b_dec_data),
    .dec_ready (b_dec_ready),
    .out_valid (b_out_valid),
    .out_wid   (b_out_wid),
    .out_data  (b_out_data),
    .out_ready (b_out_ready),
    .ibuf_pop  (b_ibuf_pop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  wid;
    logic [63:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;

  function automatic logic [63:0] pkt(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n);
  endfunction

  task automatic expect_a(input logic [1:0] w, input logic [63:0] d);
    sb_q.push_back({w, d});
  endtask

  // Scoreboard monitor: every fire must match the next expected packet.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_out_valid[0] && a_out_ready[0]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_fire", 128'(sb_q.size()), 128'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_wid", a_out_wid, mon_e.wid);
          check("sb_data", a_out_data, mon_e.data);
          check("sb_ibuf_pop", a_ibuf_pop, 4'b0001 << mon_e.wid);
        end
      end else begin
        check("ibuf_pop_idle", a_ibuf_pop, 4'b0000);
      end
    end
  end

  // Callers start and end at 1 ns after a rising edge.
  task automatic push_a(input logic [1:0] w, input logic [63:0] d);
    logic ok;
    ok          = 1'b0;
    a_dec_valid = 1'b1;
    a_dec_wid   = w;
    a_dec_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = a_dec_ready;
      @(posedge clk);
      #1;
    end
    a_dec_valid = 1'b0;
    check("push_accept", ok, 1'b1);
  endtask

  task automatic drain_a();
    a_out_ready = 1'b1;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", 128'(sb_q.size()), 128'd0);
    @(negedge clk);
    check("idle_after_drain", a_out_valid, 1'b0);
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] w, input logic [63:0] d);
    b_dec_valid = 1'b1;
    b_dec_wid   = w;
    b_dec_data  = d;
    @(negedge clk);
    check("b_push_ready", b_dec_ready, 1'b1);
    @(posedge clk);
    #1;
    b_dec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    a_dec_valid = 1'b0;
    a_dec_wid   = '0;
    a_dec_data  = '0;
    a_out_ready = 1'b0;
    b_dec_valid = 1'b0;
    b_dec_wid   = '0;
    b_dec_data  = '0;
    b_out_ready = 2'b00;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dec_ready", a_dec_ready, 1'b0);
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_ibuf_pop", a_ibuf_pop, 4'b0000);
      check("rst_b_dec_ready", b_dec_ready, 1'b0);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_dec_ready", a_dec_ready, 1'b1);
    check("post_rst_out_valid", a_out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Depth-2 fill of warp 0, full refusal during a pop, one-cycle latency.
    expect_a(2'd0, pkt(1));
    expect_a(2'd0, pkt(2));
    expect_a(2'd0, pkt(3));
    a_dec_valid = 1'b1;
    a_dec_wid   = 2'd0;
    a_dec_data  = pkt(1);
    @(negedge clk);
    check("push_a_ready", a_dec_ready, 1'b1);
    check("lat_same_cycle", a_out_valid, BYP);
    @(posedge clk);
    #1;
    a_dec_data = pkt(2);
    @(negedge clk);
    check("lat_next_valid", a_out_valid, 1'b1);
    check("lat_next_data", a_out_data, pkt(1));
    check("push_b_ready", a_dec_ready, 1'b1);
    @(posedge clk);
    #1;
    a_dec_data  = pkt(3);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("full_with_pop_ready", a_dec_ready, 1'b0);
    @(posedge clk);
    #1;
    push_a(2'd0, pkt(3));
    drain_a();

    // One entry per warp: issue 0,1,2,3.
    for (int w = 0; w < 4; w++) expect_a(2'(w), pkt(16 + w));
    for (int w = 0; w < 4; w++) push_a(2'(w), pkt(16 + w));
    drain_a();

    // Refill 2 then 0 while stalled: 2 holds the grant, then wrap to 0.
    expect_a(2'd2, pkt(32));
    expect_a(2'd0, pkt(33));
    push_a(2'd2, pkt(32));
    push_a(2'd0, pkt(33));
    drain_a();

    // Arrival 3,0,2,1 from rr_ptr=1: held 3, then round-robin gives 0,1,2.
    expect_a(2'd3, pkt(48));
    expect_a(2'd0, pkt(49));
    expect_a(2'd1, pkt(51));
    expect_a(2'd2, pkt(50));
    push_a(2'd3, pkt(48));
    push_a(2'd0, pkt(49));
    push_a(2'd2, pkt(50));
    push_a(2'd1, pkt(51));
    drain_a();

    // Stall on warp 1; a push to warp 0 must not steal the grant.
    expect_a(2'd1, pkt(64));
    expect_a(2'd0, pkt(65));
    push_a(2'd1, pkt(64));
    a_dec_valid = 1'b1;
    a_dec_wid   = 2'd0;
    a_dec_data  = pkt(65);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("stall_push_ready", a_dec_ready, 1'b1);
      check("stall_valid", a_out_valid, 1'b1);
      check("stall_wid", a_out_wid, 2'd1);
      check("stall_data", a_out_data, pkt(64));
      @(posedge clk);
      #1;
      a_dec_valid = 1'b0;
    end
    drain_a();

    // Push into an idle lane with the consumer ready.
    expect_a(2'd3, pkt(80));
    a_out_ready = 1'b1;
    a_dec_valid = 1'b1;
    a_dec_wid   = 2'd3;
    a_dec_data  = pkt(80);
    @(negedge clk);
    check("idle_push_same_valid", a_out_valid, BYP);
    check("idle_push_same_pop3", a_ibuf_pop[3], BYP);
    @(posedge clk);
    #1;
    a_dec_valid = 1'b0;
    @(negedge clk);
    check("idle_push_next_valid", a_out_valid, !BYP);
    @(posedge clk);
    #1;
    drain_a();

    // Reset with a queued entry discards it without a credit pulse.
    push_a(2'd2, pkt(96));
    reset       = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_ibuf_pop", a_ibuf_pop, 4'b0000);
    check("midrst_dec_ready", a_dec_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_discarded", a_out_valid, 1'b0);
    check("midrst_ready_after", a_dec_ready, 1'b1);
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;

    // Two lanes fire in the same cycle.
    push_b(2'd0, pkt(112));
    push_b(2'd1, pkt(113));
    b_out_ready = 2'b11;
    @(negedge clk);
    check("b_dual_valid", b_out_valid, 2'b11);
    check("b_dual_pop", b_ibuf_pop, 4'b0011);
    check("b_dual_wid", b_out_wid, 4'b0100);
    check("b_dual_data", b_out_data, {pkt(113), pkt(112)});
    @(posedge clk);
    #1;
    b_out_ready = 2'b00;
    @(negedge clk);
    check("b_empty", b_out_valid, 2'b00);
    @(posedge clk);
    #1;

    // Lanes are independent: lane 1 fires while lane 0 stalls, then swap.
    push_b(2'd2, pkt(114));
    push_b(2'd3, pkt(115));
    b_out_ready = 2'b10;
    @(negedge clk);
    check("b_lane1_valid", b_out_valid, 2'b11);
    check("b_lane1_pop", b_ibuf_pop, 4'b1000);
    check("b_lane1_data", b_out_data[127:64], pkt(115));
    @(posedge clk);
    #1;
    b_out_ready = 2'b01;
    @(negedge clk);
    check("b_lane0_valid", b_out_valid, 2'b01);
    check("b_lane0_pop", b_ibuf_pop, 4'b0100);
    check("b_lane0_data", b_out_data[63:0], pkt(114));
    @(posedge clk);
    #1;
    b_out_ready = 2'b00;
    @(negedge clk);
    check("b_final_empty", b_out_valid, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
